// File: rtl/rename_free_list_pkg.sv
// Shared widths, index types and pointer helpers for the rename free list.
package rename_free_list_pkg;

    localparam int unsigned WAY          = 4;
    localparam int unsigned RET_WAY      = 4;
    localparam int unsigned PHY_REG_CNT  = 64;
    localparam int unsigned ARCH_REG_CNT = 32;
    localparam int unsigned DEPTH        = PHY_REG_CNT - ARCH_REG_CNT;

    localparam int unsigned WAY_CNT_LEN  = $clog2(WAY + 1);
    localparam int unsigned RET_CNT_LEN  = $clog2(RET_WAY + 1);
    localparam int unsigned ARCH_IDX_LEN = $clog2(ARCH_REG_CNT);
    localparam int unsigned PHY_IDX_LEN  = $clog2(PHY_REG_CNT);
    localparam int unsigned PTR_LEN      = $clog2(DEPTH) + 1;

    typedef logic [ARCH_IDX_LEN-1:0] arch_reg_idx_t;
    typedef logic [PHY_IDX_LEN-1:0]  phy_reg_idx_t;
    typedef logic [PTR_LEN-1:0]      fl_ptr_t;
    typedef logic [PTR_LEN-2:0]      fl_slot_t;
    typedef logic [WAY_CNT_LEN-1:0]  way_cnt_t;
    typedef logic [RET_CNT_LEN-1:0]  ret_cnt_t;

    // Array slot addressed by a wrap-bit pointer.
    function automatic fl_slot_t fl_slot(input fl_ptr_t p);
        return p[PTR_LEN-2:0];
    endfunction

endpackage

// File: rtl/rename_free_list_if.sv
// Rename-stage handshake between dispatch/retire and the free list.
interface rename_free_list_if;
    import rename_free_list_pkg::*;

    way_cnt_t                     num_to_dispatch;
    arch_reg_idx_t [WAY-1:0]      arch_dest_reg;
    phy_reg_idx_t  [WAY-1:0]      dispatch_free_reg;
    way_cnt_t                     free_reg_valid;
    ret_cnt_t                     num_to_retire;
    logic          [RET_WAY-1:0]  retire_has_dest;
    phy_reg_idx_t  [RET_WAY-1:0]  retire_free_reg;
    logic                         squash;
    logic                         overflow_err;

    modport master (
        output num_to_dispatch, arch_dest_reg, num_to_retire,
               retire_has_dest, retire_free_reg, squash,
        input  dispatch_free_reg, free_reg_valid, overflow_err
    );

    modport free_list (
        input  num_to_dispatch, arch_dest_reg, num_to_retire,
               retire_has_dest, retire_free_reg, squash,
        output dispatch_free_reg, free_reg_valid, overflow_err
    );

    modport slave (
        input  num_to_dispatch, arch_dest_reg, num_to_retire,
               retire_has_dest, retire_free_reg, squash,
        output dispatch_free_reg, free_reg_valid, overflow_err
    );

endinterface

// File: rtl/rename_free_list_lane_compact.sv
// Exclusive prefix count over a lane mask: offset of each lane among set lanes, plus total.
module rename_free_list_lane_compact #(
    parameter int unsigned N     = 4,
    parameter int unsigned CNT_W = $clog2(N + 1)
) (
    input  logic [N-1:0]            valid_i,
    output logic [N-1:0][CNT_W-1:0] offset_o,
    output logic [CNT_W-1:0]        total_o
);

    always_comb begin
        logic [CNT_W-1:0] run;
        run = '0;
        for (int unsigned i = 0; i < N; i++) begin
            offset_o[i] = run;
            run         = run + CNT_W'(valid_i[i]);
        end
        total_o = run;
    end

endmodule

// File: rtl/rename_free_list.sv
// Physical-register free list: compacted multi-lane allocate, retire release,
// and single-cycle squash recovery via a retirement-point head pointer.
module rename_free_list
    import rename_free_list_pkg::*;
(
    input  logic                  clock,
    input  logic                  reset_n,
    rename_free_list_if.free_list fl
);

    phy_reg_idx_t entries_q [DEPTH];
    phy_reg_idx_t entries_d [DEPTH];
    fl_ptr_t      head_q, head_d;
    fl_ptr_t      arch_head_q, arch_head_d;
    fl_ptr_t      tail_q, tail_d;
    logic         overflow_q, overflow_d;

    logic [WAY-1:0]                       disp_need;
    logic [WAY-1:0][WAY_CNT_LEN-1:0]      disp_off;
    way_cnt_t                             alloc_n;
    logic [RET_WAY-1:0]                   rel_valid;
    logic [RET_WAY-1:0][RET_CNT_LEN-1:0]  rel_off;
    ret_cnt_t                             rel_n;

    fl_ptr_t free_count;
    logic    alloc_ok;
    logic    rel_ok;

    always_comb begin
        for (int unsigned i = 0; i < WAY; i++) begin
            disp_need[i] = (i < 32'(fl.num_to_dispatch)) && (fl.arch_dest_reg[i] != '0);
        end
        for (int unsigned k = 0; k < RET_WAY; k++) begin
            rel_valid[k] = (k < 32'(fl.num_to_retire)) && fl.retire_has_dest[k];
        end
    end

    rename_free_list_lane_compact #(
        .N     (WAY),
        .CNT_W (WAY_CNT_LEN)
    ) u_disp_compact (
        .valid_i  (disp_need),
        .offset_o (disp_off),
        .total_o  (alloc_n)
    );

    rename_free_list_lane_compact #(
        .N     (RET_WAY),
        .CNT_W (RET_CNT_LEN)
    ) u_ret_compact (
        .valid_i  (rel_valid),
        .offset_o (rel_off),
        .total_o  (rel_n)
    );

    assign free_count = tail_q - head_q;
    // Allocation is all-or-nothing and suppressed during squash.
    assign alloc_ok   = !fl.squash && (fl_ptr_t'(alloc_n) <= free_count);
    assign rel_ok     = fl_ptr_t'(rel_n) <= (fl_ptr_t'(DEPTH) - free_count);

    always_comb begin
        for (int unsigned i = 0; i < WAY; i++) begin
            fl.dispatch_free_reg[i] = '0;
            if (alloc_ok && disp_need[i]) begin
                fl.dispatch_free_reg[i] = entries_q[fl_slot(head_q + fl_ptr_t'(disp_off[i]))];
            end
        end
    end

    assign fl.free_reg_valid = (free_count < fl_ptr_t'(WAY)) ? way_cnt_t'(free_count)
                                                               : way_cnt_t'(WAY);
    assign fl.overflow_err   = overflow_q;

    always_comb begin
        entries_d   = entries_q;
        tail_d      = tail_q;
        arch_head_d = arch_head_q;
        overflow_d  = overflow_q;
        head_d      = head_q;

        if (rel_n != '0) begin
            if (rel_ok) begin
                for (int unsigned k = 0; k < RET_WAY; k++) begin
                    if (rel_valid[k]) begin
                        entries_d[fl_slot(tail_q + fl_ptr_t'(rel_off[k]))] = fl.retire_free_reg[k];
                    end
                end
                tail_d      = tail_q + fl_ptr_t'(rel_n);
                arch_head_d = arch_head_q + fl_ptr_t'(rel_n);
            end else begin
                overflow_d = 1'b1;
            end
        end

        // Squash rewinds to the post-retire arch point; the squashed entries are still in place.
        if (fl.squash) begin
            head_d = arch_head_d;
        end else if (alloc_ok) begin
            head_d = head_q + fl_ptr_t'(alloc_n);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                entries_q[i] <= phy_reg_idx_t'(ARCH_REG_CNT + i);
            end
            head_q      <= '0;
            arch_head_q <= '0;
            tail_q      <= fl_ptr_t'(DEPTH);
            overflow_q  <= 1'b0;
        end else begin
            entries_q   <= entries_d;
            head_q      <= head_d;
            arch_head_q <= arch_head_d;
            tail_q      <= tail_d;
            overflow_q  <= overflow_d;
        end
    end

endmodule

// File: tb/tb_rename_free_list.sv
// Bench for rename_free_list: directed vector table, corner sequences, and a
// randomized run against a queue-based reference model.
`timescale 1ns/1ps
module tb_rename_free_list;
    import rename_free_list_pkg::*;

    typedef arch_reg_idx_t [WAY-1:0]     dest_vec_t;
    typedef phy_reg_idx_t  [WAY-1:0]     reg_vec_t;
    typedef phy_reg_idx_t  [RET_WAY-1:0] ret_vec_t;

    typedef struct {
        way_cnt_t           nd;
        dest_vec_t          dest;
        ret_cnt_t           nr;
        logic [RET_WAY-1:0] has;
        ret_vec_t           rr;
        logic               sq;
        reg_vec_t           exp_reg;
        way_cnt_t           exp_valid;
        logic               exp_ovf;
    } vec_t;

    localparam int NVEC = 10;

    logic clock = 1'b0;
    logic reset_n;
    always #5 clock = ~clock;

    rename_free_list_if fl();

    rename_free_list dut (
        .clock   (clock),
        .reset_n (reset_n),
        .fl      (fl)
    );

    int n_vec;
    int n_bad;

    phy_reg_idx_t free_q [$];
    phy_reg_idx_t infl_q [$];
    phy_reg_idx_t arch_q [$];

    vec_t tbl [NVEC];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic dest_vec_t dv(input int unsigned a, b, c, d);
        dest_vec_t v;
        v[0] = arch_reg_idx_t'(a); v[1] = arch_reg_idx_t'(b);
        v[2] = arch_reg_idx_t'(c); v[3] = arch_reg_idx_t'(d);
        return v;
    endfunction

    function automatic reg_vec_t rv(input int unsigned a, b, c, d);
        reg_vec_t v;
        v[0] = phy_reg_idx_t'(a); v[1] = phy_reg_idx_t'(b);
        v[2] = phy_reg_idx_t'(c); v[3] = phy_reg_idx_t'(d);
        return v;
    endfunction

    function automatic ret_vec_t tv(input int unsigned a, b, c, d);
        ret_vec_t v;
        v[0] = phy_reg_idx_t'(a); v[1] = phy_reg_idx_t'(b);
        v[2] = phy_reg_idx_t'(c); v[3] = phy_reg_idx_t'(d);
        return v;
    endfunction

    task automatic drive(input way_cnt_t nd, input dest_vec_t dest, input ret_cnt_t nr,
                         input logic [RET_WAY-1:0] has, input ret_vec_t rr, input logic sq);
        fl.num_to_dispatch = nd;
        fl.arch_dest_reg   = dest;
        fl.num_to_retire   = nr;
        fl.retire_has_dest = has;
        fl.retire_free_reg = rr;
        fl.squash          = sq;
    endtask

    task automatic idle();
        drive('0, '0, '0, '0, '0, 1'b0);
    endtask

    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic model_reset();
        free_q.delete(); infl_q.delete(); arch_q.delete();
        for (int unsigned i = 0; i < DEPTH; i++) free_q.push_back(phy_reg_idx_t'(ARCH_REG_CNT + i));
        for (int unsigned i = 0; i < ARCH_REG_CNT; i++) arch_q.push_back(phy_reg_idx_t'(i));
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        idle();
        #13;
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        model_reset();
    endtask

    // n needing lanes, expected registers first..first+n-1 in lanes 0..n-1.
    task automatic alloc_expect(input string name, input int unsigned n, input int unsigned first);
        dest_vec_t d;
        reg_vec_t  e;
        d = '0;
        e = '0;
        for (int unsigned i = 0; i < n; i++) begin
            d[i] = arch_reg_idx_t'(i + 1);
            e[i] = phy_reg_idx_t'(first + i);
        end
        drive(way_cnt_t'(n), d, '0, '0, '0, 1'b0);
        #4;
        check(name, 64'(fl.dispatch_free_reg), 64'(e));
        next_cycle();
    endtask

    task automatic random_test(input int unsigned cycles);
        way_cnt_t           nd;
        dest_vec_t          dest;
        ret_cnt_t           nr;
        logic [RET_WAY-1:0] has;
        ret_vec_t           rr;
        logic               sq;
        reg_vec_t           exp;
        int                 need, avail, j, fsz;
        int unsigned        idx;
        logic               alloc;
        phy_reg_idx_t       rel [$];
        for (int unsigned c = 0; c < cycles; c++) begin
            nd = way_cnt_t'($urandom_range(0, WAY));
            for (int unsigned i = 0; i < WAY; i++) begin
                dest[i] = ($urandom_range(0, 3) == 0) ? '0
                        : arch_reg_idx_t'($urandom_range(1, ARCH_REG_CNT - 1));
            end
            sq    = ($urandom_range(0, 15) == 0);
            nr    = ret_cnt_t'($urandom_range(0, RET_WAY));
            avail = infl_q.size();
            has   = '0;
            rr    = '0;
            rel.delete();
            // Active retires release a stale architectural register; inactive lanes carry junk.
            for (int unsigned k = 0; k < RET_WAY; k++) begin
                if ($urandom_range(0, 1) == 1) begin
                    if (k < 32'(nr)) begin
                        if (avail > 0) begin
                            avail--;
                            has[k] = 1'b1;
                            idx    = $urandom_range(0, arch_q.size() - 1);
                            rr[k]  = arch_q[idx];
                            arch_q.delete(idx);
                            rel.push_back(rr[k]);
                        end
                    end else begin
                        has[k] = 1'b1;
                        rr[k]  = phy_reg_idx_t'($urandom);
                    end
                end
            end

            need = 0;
            for (int unsigned i = 0; i < 32'(nd); i++) if (dest[i] != '0) need++;
            fsz   = free_q.size();
            alloc = !sq && (need <= fsz);
            exp   = '0;
            if (alloc) begin
                j = 0;
                for (int unsigned i = 0; i < 32'(nd); i++) begin
                    if (dest[i] != '0) begin
                        exp[i] = free_q[j];
                        j++;
                    end
                end
            end

            drive(nd, dest, nr, has, rr, sq);
            #4;
            check($sformatf("rand%0d_regs", c), 64'(fl.dispatch_free_reg), 64'(exp));
            check($sformatf("rand%0d_valid", c), 64'(fl.free_reg_valid),
                  64'((fsz < int'(WAY)) ? fsz : int'(WAY)));
            check($sformatf("rand%0d_ovf", c), 64'(fl.overflow_err), 64'(0));

            for (int r = 0; r < rel.size(); r++) arch_q.push_back(infl_q.pop_front());
            if (alloc) repeat (need) infl_q.push_back(free_q.pop_front());
            foreach (rel[r]) free_q.push_back(rel[r]);
            if (sq) begin
                while (infl_q.size() > 0) free_q.push_front(infl_q.pop_back());
            end
            next_cycle();
        end
    endtask

    initial begin
        n_vec   = 0;
        n_bad   = 0;
        reset_n = 1'b1;
        idle();

        tbl[0] = '{4, dv(1,2,3,4), 0, 4'b0000, tv(0,0,0,0), 0, rv(32,33,34,35), 4, 0};
        tbl[1] = '{4, dv(5,0,7,0), 0, 4'b0000, tv(0,0,0,0), 0, rv(36,0,37,0),   4, 0};
        tbl[2] = '{0, dv(9,9,9,9), 0, 4'b0000, tv(0,0,0,0), 0, rv(0,0,0,0),     4, 0};
        tbl[3] = '{2, dv(0,9,3,3), 0, 4'b0000, tv(0,0,0,0), 0, rv(0,38,0,0),    4, 0};
        tbl[4] = '{0, dv(0,0,0,0), 2, 4'b0011, tv(3,4,0,0), 0, rv(0,0,0,0),     4, 0};
        tbl[5] = '{0, dv(0,0,0,0), 0, 4'b0000, tv(0,0,0,0), 1, rv(0,0,0,0),     4, 0};
        tbl[6] = '{4, dv(1,1,1,1), 0, 4'b0000, tv(0,0,0,0), 0, rv(34,35,36,37), 4, 0};
        tbl[7] = '{4, dv(1,1,1,1), 1, 4'b1111, tv(10,11,12,13), 1, rv(0,0,0,0), 4, 0};
        tbl[8] = '{1, dv(2,0,0,0), 4, 4'b0000, tv(0,0,0,0), 0, rv(35,0,0,0),    4, 0};
        tbl[9] = '{4, dv(3,3,3,3), 0, 4'b0000, tv(0,0,0,0), 0, rv(36,37,38,39), 4, 0};

        #1;
        do_reset();
        #4;
        check("reset_regs",  64'(fl.dispatch_free_reg), 64'(0));
        check("reset_valid", 64'(fl.free_reg_valid),    64'(4));
        check("reset_ovf",   64'(fl.overflow_err),      64'(0));
        next_cycle();

        for (int i = 0; i < NVEC; i++) begin
            drive(tbl[i].nd, tbl[i].dest, tbl[i].nr, tbl[i].has, tbl[i].rr, tbl[i].sq);
            #4;
            check($sformatf("vec%0d_regs", i),  64'(fl.dispatch_free_reg), 64'(tbl[i].exp_reg));
            check($sformatf("vec%0d_valid", i), 64'(fl.free_reg_valid),    64'(tbl[i].exp_valid));
            check($sformatf("vec%0d_ovf", i),   64'(fl.overflow_err),      64'(tbl[i].exp_ovf));
            next_cycle();
        end

        // Near-empty list: an oversized request must allocate nothing.
        do_reset();
        for (int unsigned k = 0; k < 7; k++) alloc_expect($sformatf("A_fill%0d", k), 4, 32 + 4 * k);
        alloc_expect("A_fill7", 3, 60);
        idle();
        #4;
        check("A_valid_one", 64'(fl.free_reg_valid), 64'(1));
        next_cycle();
        drive(2, dv(1,2,0,0), '0, '0, '0, 1'b0);
        #4;
        check("A_atomic_regs", 64'(fl.dispatch_free_reg), 64'(0));
        next_cycle();
        idle();
        #4;
        check("A_valid_kept", 64'(fl.free_reg_valid), 64'(1));
        next_cycle();
        alloc_expect("A_last", 1, 63);
        idle();
        #4;
        check("A_valid_empty", 64'(fl.free_reg_valid), 64'(0));
        next_cycle();

        // Retire plus squash in the same cycle, then walk the list into the wrapped slots.
        do_reset();
        alloc_expect("B_alloc0", 4, 32);
        alloc_expect("B_alloc1", 4, 36);
        drive(4, dv(1,1,1,1), 3, 4'b0111, tv(5,6,7,0), 1'b1);
        #4;
        check("B_squash_regs", 64'(fl.dispatch_free_reg), 64'(0));
        next_cycle();
        idle();
        #4;
        check("B_valid_after", 64'(fl.free_reg_valid), 64'(4));
        next_cycle();
        alloc_expect("B_resume", 4, 35);
        for (int unsigned k = 0; k < 6; k++) alloc_expect($sformatf("B_walk%0d", k), 4, 39 + 4 * k);
        alloc_expect("B_walk_last", 1, 63);
        drive(3, dv(1,2,3,0), '0, '0, '0, 1'b0);
        #4;
        check("B_wrapped_regs", 64'(fl.dispatch_free_reg), 64'(rv(5,6,7,0)));
        next_cycle();
        idle();
        #4;
        check("B_valid_empty", 64'(fl.free_reg_valid), 64'(0));
        next_cycle();

        // Release into a full list is dropped and latches the sticky error.
        do_reset();
        drive(0, '0, 1, 4'b0001, tv(5,0,0,0), 1'b0);
        #4;
        check("C_ovf_pre", 64'(fl.overflow_err), 64'(0));
        next_cycle();
        idle();
        #4;
        check("C_ovf_set",   64'(fl.overflow_err),   64'(1));
        check("C_valid_full", 64'(fl.free_reg_valid), 64'(4));
        next_cycle();
        alloc_expect("C_tail_kept", 4, 32);
        idle();
        #4;
        check("C_ovf_sticky", 64'(fl.overflow_err), 64'(1));
        reset_n = 1'b0;
        #1;
        check("C_ovf_async_clr", 64'(fl.overflow_err), 64'(0));

        do_reset();
        random_test(10000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
